// File: rtl/pwm_duty_ramp_if.sv
// Target-duty handshake between a controller and pwm_duty_ramp.
// The controller offers target_duty/target_valid; the ramp answers with target_ready.
interface pwm_duty_ramp_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] target_duty;
  logic             target_valid;
  logic             target_ready;

  modport master (
    output target_duty,
    output target_valid,
    input  target_ready
  );

  modport slave (
    input  target_duty,
    input  target_valid,
    output target_ready
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty source feeding pwm: walks duty_cycle toward an accepted target in STEP-sized steps every STEP_DIV clocks.
// Targets are only accepted while idle (target_ready low during a ramp); hold freezes the divider and duty.
module pwm_duty_ramp #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int STEP_DIV  = 16,
  parameter int INIT_DUTY = 0
) (
  input  logic             clk,
  input  logic             reset,
  pwm_duty_ramp_if.slave   tgt,
  input  logic             hold,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             ramp_busy,
  output logic             ramp_done
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_DUTY);
  localparam logic [15:0]      DIV_LAST = 16'(STEP_DIV - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_q_n;
  logic [WIDTH-1:0] duty_n;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_amt;
  logic [15:0]      div_cnt;
  logic [15:0]      div_n;
  logic             done_n;

  assign tgt.target_ready = (state == IDLE);
  assign ramp_busy        = (state == RAMP_UP) || (state == RAMP_DOWN);

  // Remaining distance is always non-negative in the ramp direction, so the
  // clamped step can never carry past the target or wrap.
  assign diff     = (state == RAMP_UP) ? (target_q - duty_cycle) : (duty_cycle - target_q);
  assign step_amt = (diff < STEP_W) ? diff : STEP_W;

  always_comb begin
    state_n    = state;
    target_q_n = target_q;
    duty_n     = duty_cycle;
    div_n      = div_cnt;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (tgt.target_valid) begin
          target_q_n = tgt.target_duty;
          div_n      = '0;
          if (tgt.target_duty > duty_cycle) begin
            state_n = RAMP_UP;
          end else if (tgt.target_duty < duty_cycle) begin
            state_n = RAMP_DOWN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (!hold) begin
          if (div_cnt == DIV_LAST) begin
            div_n  = '0;
            duty_n = (state == RAMP_UP) ? (duty_cycle + step_amt) : (duty_cycle - step_amt);
            if (step_amt == diff) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            div_n = div_cnt + 16'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      duty_cycle <= INIT_W;
      target_q   <= INIT_W;
      div_cnt    <= '0;
      ramp_done  <= 1'b0;
    end else begin
      state      <= state_n;
      duty_cycle <= duty_n;
      target_q   <= target_q_n;
      div_cnt    <= div_n;
      ramp_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected step values and edge offsets are queued at each handshake.
module tb_pwm_duty_ramp;

  localparam int STEP     = 8;
  localparam int STEP_DIV = 4;
  localparam int NOHOLD   = 1 << 20;

  typedef struct {
    logic [7:0] duty;
    int         off;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       hold;
  logic [7:0] duty_cycle;
  logic       ramp_busy;
  logic       ramp_done;

  pwm_duty_ramp_if #(.WIDTH(8)) tif ();

  pwm_duty_ramp #(
    .WIDTH(8),
    .STEP(STEP),
    .STEP_DIV(STEP_DIV),
    .INIT_DUTY(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tgt(tif),
    .hold(hold),
    .duty_cycle(duty_cycle),
    .ramp_busy(ramp_busy),
    .ramp_done(ramp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  int         cur;
  int         exp_done;
  int         done_cnt;
  int         done_first;
  int         busy_cnt;
  int         ready_early;
  logic [7:0] prev_duty;
  ev_t        exp_q[$];
  ev_t        obs_q[$];

  // Reference model: clamped steps from the bench's own idea of the current duty.
  task automatic push_expected(input int t, input int hold_at, input int hold_len);
    int  d;
    int  k;
    int  off;
    ev_t e;
    d = cur;
    k = 0;
    exp_q.delete();
    exp_done = 0;
    while (d != t) begin
      if (t > d) d = d + (((t - d) < STEP) ? (t - d) : STEP);
      else       d = d - (((d - t) < STEP) ? (d - t) : STEP);
      k++;
      off = STEP_DIV * k;
      if (off > hold_at) off = off + hold_len;
      e.duty = 8'(d);
      e.off  = off;
      exp_q.push_back(e);
      exp_done = off;
    end
    cur = t;
  endtask

  task automatic send_target(input int t);
    prev_duty = duty_cycle;
    tif.target_duty  = 8'(t);
    tif.target_valid = 1'b1;
    @(posedge clk);
    #1;
    tif.target_valid = 1'b0;
  endtask

  // Records duty changes and status per cycle; offset 0 is the sample just after the handshake edge.
  task automatic observe(input int ncyc, input int hold_at, input int hold_len, input bit junk);
    ev_t o;
    obs_q.delete();
    done_cnt    = 0;
    done_first  = -1;
    busy_cnt    = 0;
    ready_early = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (duty_cycle !== prev_duty) begin
        o.duty = duty_cycle;
        o.off  = c;
        obs_q.push_back(o);
        prev_duty = duty_cycle;
      end
      if (ramp_done === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
      end
      if (ramp_busy === 1'b1) busy_cnt++;
      if (tif.target_ready === 1'b1 && done_first < 0) ready_early++;
      hold = (c >= hold_at) && (c < hold_at + hold_len);
      if (junk) begin
        tif.target_duty  = 8'd0;
        tif.target_valid = (c >= 1) && (c <= 5);
      end
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    tif.target_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tests++; if (duty_cycle !== 8'd0) begin fails++; $display("FAIL reset_duty: got %0d expected 0", duty_cycle); end
    tests++; if (tif.target_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", tif.target_ready); end
    tests++; if (ramp_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", ramp_busy); end
    tests++; if (ramp_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", ramp_done); end
    @(posedge clk);
    #1;
    cur = 0;
  endtask

  task automatic test_ramp_up();
    ev_t e;
    ev_t o;
    push_expected(64, NOHOLD, 0);
    send_target(64);
    observe(exp_done + 4, NOHOLD, 0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL ramp_up_step: missing, expected duty %0d at offset %0d", e.duty, e.off);
      end else begin
        o = obs_q.pop_front();
        if (o.duty !== e.duty || o.off !== e.off) begin
          fails++; $display("FAIL ramp_up_step: got %0d at offset %0d, expected %0d at %0d", o.duty, o.off, e.duty, e.off);
        end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL ramp_up_extra: %0d unexpected duty changes, expected 0", obs_q.size()); end
    tests++; if (done_cnt !== 1 || done_first !== exp_done) begin fails++; $display("FAIL ramp_up_done: %0d pulses first at %0d, expected 1 at %0d", done_cnt, done_first, exp_done); end
    tests++; if (busy_cnt !== exp_done) begin fails++; $display("FAIL ramp_up_busy: %0d busy cycles, expected %0d", busy_cnt, exp_done); end
    tests++; if (ready_early !== 0) begin fails++; $display("FAIL ramp_up_ready: ready high %0d cycles mid-ramp, expected 0", ready_early); end
  endtask

  task automatic test_equal();
    push_expected(64, NOHOLD, 0);
    send_target(64);
    observe(6, NOHOLD, 0, 1'b0);
    tests++; if (obs_q.size() != 0 || duty_cycle !== 8'd64) begin fails++; $display("FAIL equal_duty: %0d changes, duty %0d, expected 0 changes duty 64", obs_q.size(), duty_cycle); end
    tests++; if (done_cnt !== 1 || done_first !== 0) begin fails++; $display("FAIL equal_done: %0d pulses first at %0d, expected 1 at 0", done_cnt, done_first); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL equal_busy: %0d busy cycles, expected 0", busy_cnt); end
  endtask

  task automatic test_clamp();
    int  tgts[3];
    ev_t e;
    ev_t o;
    tgts[0] = 60;
    tgts[1] = 250;
    tgts[2] = 255;
    for (int i = 0; i < 3; i++) begin
      push_expected(tgts[i], NOHOLD, 0);
      send_target(tgts[i]);
      observe(exp_done + 4, NOHOLD, 0, 1'b0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (obs_q.size() == 0) begin
          fails++; $display("FAIL clamp_step(%0d): missing, expected duty %0d at offset %0d", tgts[i], e.duty, e.off);
        end else begin
          o = obs_q.pop_front();
          if (o.duty !== e.duty || o.off !== e.off) begin
            fails++; $display("FAIL clamp_step(%0d): got %0d at offset %0d, expected %0d at %0d", tgts[i], o.duty, o.off, e.duty, e.off);
          end
        end
      end
      tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL clamp_extra(%0d): %0d unexpected changes, expected 0", tgts[i], obs_q.size()); end
      tests++; if (done_cnt !== 1 || done_first !== exp_done) begin fails++; $display("FAIL clamp_done(%0d): %0d pulses first at %0d, expected 1 at %0d", tgts[i], done_cnt, done_first, exp_done); end
      tests++; if (duty_cycle !== 8'(tgts[i])) begin fails++; $display("FAIL clamp_final(%0d): got %0d expected %0d", tgts[i], duty_cycle, tgts[i]); end
    end
  endtask

  task automatic test_reset_midramp();
    int  c;
    int  chg;
    int  dn;
    ev_t e;
    ev_t o;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur = 0;
    send_target(64);
    c = 0;
    while (duty_cycle !== 8'd32 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    tests++; if (c !== 16) begin fails++; $display("FAIL midramp_reach32: reached at offset %0d, expected 16", c); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tests++; if (duty_cycle !== 8'd0) begin fails++; $display("FAIL midramp_duty: got %0d expected 0", duty_cycle); end
    tests++; if (tif.target_ready !== 1'b1 || ramp_busy !== 1'b0) begin fails++; $display("FAIL midramp_state: ready %b busy %b, expected 1 0", tif.target_ready, ramp_busy); end
    chg = 0;
    dn  = 0;
    for (int i = 0; i < 12; i++) begin
      if (duty_cycle !== 8'd0) chg++;
      if (ramp_done !== 1'b0) dn++;
      @(posedge clk);
      #1;
    end
    tests++; if (chg !== 0 || dn !== 0) begin fails++; $display("FAIL midramp_quiet: %0d nonzero duty, %0d done cycles, expected 0 0", chg, dn); end
    cur = 0;
    push_expected(16, NOHOLD, 0);
    send_target(16);
    observe(exp_done + 4, NOHOLD, 0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL midramp_fresh_step: missing, expected %0d at offset %0d", e.duty, e.off);
      end else begin
        o = obs_q.pop_front();
        if (o.duty !== e.duty || o.off !== e.off) begin
          fails++; $display("FAIL midramp_fresh_step: got %0d at offset %0d, expected %0d at %0d", o.duty, o.off, e.duty, e.off);
        end
      end
    end
    tests++; if (done_cnt !== 1 || done_first !== exp_done) begin fails++; $display("FAIL midramp_fresh_done: %0d pulses first at %0d, expected 1 at %0d", done_cnt, done_first, exp_done); end
  endtask

  task automatic test_hold_ignore();
    ev_t e;
    ev_t o;
    push_expected(80, 10, 10);
    send_target(80);
    observe(exp_done + 4, 10, 10, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL hold_step: missing, expected %0d at offset %0d", e.duty, e.off);
      end else begin
        o = obs_q.pop_front();
        if (o.duty !== e.duty || o.off !== e.off) begin
          fails++; $display("FAIL hold_step: got %0d at offset %0d, expected %0d at %0d", o.duty, o.off, e.duty, e.off);
        end
      end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL hold_extra: %0d unexpected changes, expected 0", obs_q.size()); end
    tests++; if (done_cnt !== 1 || done_first !== exp_done) begin fails++; $display("FAIL hold_done: %0d pulses first at %0d, expected 1 at %0d", done_cnt, done_first, exp_done); end
    tests++; if (busy_cnt !== exp_done) begin fails++; $display("FAIL hold_busy: %0d busy cycles, expected %0d", busy_cnt, exp_done); end
    tests++; if (duty_cycle !== 8'd80) begin fails++; $display("FAIL hold_final: got %0d expected 80", duty_cycle); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    cur   = 0;
    reset = 1'b0;
    hold  = 1'b0;
    tif.target_duty  = 8'd0;
    tif.target_valid = 1'b0;
    test_reset();
    test_ramp_up();
    test_equal();
    test_clamp();
    test_reset_midramp();
    test_hold_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
